// File: rtl/uart_tx_if.sv
// FIFO/THR-to-transmitter handshake: character data, holding-register-empty flag and pop strobe.
interface uart_tx_if;
  logic [7:0] din;
  logic       thre;
  logic       pop;

  modport master (output din, output thre, input pop);
  modport slave  (input din, input thre, output pop);
endinterface

// File: rtl/uart_tx.sv
// 16550-style UART transmitter: start, 5-8 data bits LSB-first, optional parity, 1/2 stop bits.
// Define UART_TX_HALF_STOP_EN to get 1.5 stop bits for 5-bit words when stb=1.
module uart_tx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic       pen,
  input  logic       stb,
  input  logic       sticky_parity,
  input  logic       eps,
  input  logic       set_break,
  input  logic [1:0] wls,
  uart_tx_if.slave   fifo,
  output logic       sreg_empty,
  output logic       tx
);

  localparam int CW = $clog2(2 * OVERSAMPLE);
  localparam logic [CW-1:0] BIT_END    = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] DOUBLE_END = CW'(2 * OVERSAMPLE - 1);
`ifdef UART_TX_HALF_STOP_EN
  localparam logic [CW-1:0] HALF_END   = CW'(OVERSAMPLE * 3 / 2 - 1);
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic [CW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_acc;
  logic [1:0]    wls_q;
  logic          pen_q;
  logic          eps_q;
  logic          sticky_q;
  logic          stb_q;
  logic          tx_q;
  logic          pop_q;

  logic [CW-1:0] stop_end;
  logic          bit_done;
  logic          last_data;
  logic          par_bit;
  logic          load;

  // Stop length depends only on the settings latched with the current frame.
  always_comb begin
    stop_end = BIT_END;
    if (stb_q) begin
`ifdef UART_TX_HALF_STOP_EN
      if (wls_q == 2'b00)
        stop_end = HALF_END;
      else
        stop_end = DOUBLE_END;
`else
      stop_end = DOUBLE_END;
`endif
    end
  end

  assign bit_done  = (tick_cnt == BIT_END);
  assign last_data = (bit_cnt == ({1'b0, wls_q} + 3'd4));
  assign par_bit   = sticky_q ? ~eps_q : (par_acc ^ shreg[0] ^ ~eps_q);

  // A new character is taken from idle, or on the final stop tick so frames run back-to-back.
  assign load = baud_pulse && !fifo.thre &&
                ((state == IDLE) || ((state == STOP) && (tick_cnt == stop_end)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_acc    <= 1'b0;
      wls_q      <= '0;
      pen_q      <= 1'b0;
      eps_q      <= 1'b0;
      sticky_q   <= 1'b0;
      stb_q      <= 1'b0;
      tx_q       <= 1'b1;
      pop_q      <= 1'b0;
      sreg_empty <= 1'b1;
    end else begin
      pop_q <= 1'b0;
      if (load) begin
        shreg      <= fifo.din;
        wls_q      <= wls;
        pen_q      <= pen;
        eps_q      <= eps;
        sticky_q   <= sticky_parity;
        stb_q      <= stb;
        pop_q      <= 1'b1;
        sreg_empty <= 1'b0;
        tx_q       <= 1'b0;
        tick_cnt   <= '0;
        bit_cnt    <= '0;
        par_acc    <= 1'b0;
        state      <= START;
      end else if (baud_pulse) begin
        case (state)
          IDLE: begin
            tx_q       <= 1'b1;
            sreg_empty <= 1'b1;
          end
          START: begin
            if (bit_done) begin
              tick_cnt <= '0;
              tx_q     <= shreg[0];
              state    <= DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          DATA: begin
            if (bit_done) begin
              tick_cnt <= '0;
              shreg    <= {1'b0, shreg[7:1]};
              par_acc  <= par_acc ^ shreg[0];
              bit_cnt  <= bit_cnt + 1'b1;
              if (last_data) begin
                if (pen_q) begin
                  tx_q  <= par_bit;
                  state <= PARITY;
                end else begin
                  tx_q  <= 1'b1;
                  state <= STOP;
                end
              end else begin
                tx_q <= shreg[1];
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          PARITY: begin
            if (bit_done) begin
              tick_cnt <= '0;
              tx_q     <= 1'b1;
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          STOP: begin
            if (tick_cnt == stop_end) begin
              tick_cnt   <= '0;
              sreg_empty <= 1'b1;
              state      <= IDLE;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign fifo.pop = pop_q;
  assign tx       = tx_q & ~set_break;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: expected serial bits are queued when a character is offered
// and popped as the line is sampled mid-bit.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_pulse;
  logic       pen;
  logic       stb;
  logic       sticky_parity;
  logic       eps;
  logic       set_break;
  logic [1:0] wls;
  logic       sreg_empty;
  logic       tx;

  int   total = 0;
  int   bad   = 0;
  int   baud_cnt = 0;
  logic exp_q[$];

  uart_tx_if fifo();

  uart_tx #(.OVERSAMPLE(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .baud_pulse    (baud_pulse),
    .pen           (pen),
    .stb           (stb),
    .sticky_parity (sticky_parity),
    .eps           (eps),
    .set_break     (set_break),
    .wls           (wls),
    .fifo          (fifo),
    .sreg_empty    (sreg_empty),
    .tx            (tx)
  );

  always #5 clk = ~clk;

  // One baud tick every 6th clock, changed on the falling edge.
  initial begin
    baud_pulse = 1'b0;
    forever begin
      @(negedge clk);
      if (baud_cnt == 5) begin
        baud_pulse = 1'b1;
        baud_cnt   = 0;
      end else begin
        baud_pulse = 1'b0;
        baud_cnt++;
      end
    end
  end

  task automatic wait_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      int guard;
      guard = 0;
      do begin
        @(posedge clk);
        guard++;
      end while (!baud_pulse && guard < 20);
      if (!baud_pulse) begin
        total++; bad++;
        $display("[TB] FAIL baud_wait: got no tick in %0d clocks, want one", guard);
      end
    end
  endtask

  task automatic push_frame(input logic [7:0] d, input logic [1:0] w, input logic p,
                            input logic e, input logic s, input logic sb);
    int   n;
    logic ones;
    n    = int'(w) + 5;
    ones = 1'b0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(d[i]);
      ones ^= d[i];
    end
    if (p) exp_q.push_back(s ? ~e : (e ? ones : ~ones));
    exp_q.push_back(1'b1);
    if (sb) exp_q.push_back(1'b1);
  endtask

  task automatic set_cfg(input logic [1:0] w, input logic p, input logic e,
                         input logic s, input logic sb);
    wls = w; pen = p; eps = e; sticky_parity = s; stb = sb;
  endtask

  task automatic wait_pop(input string tag);
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (fifo.pop !== 1'b1 && g < 200);
    total++;
    if (fifo.pop !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s_pop: got %b want 1 within 200 clocks", tag, fifo.pop);
    end
  endtask

  // Samples each queued bit mid-bit; optionally pulses set_break inside bit brk_at.
  task automatic check_bits(input int n, input int brk_at, input string tag);
    logic want;
    for (int k = 0; k < n; k++) begin
      want = 1'b1;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL %s_queue: got empty scoreboard want bit %0d", tag, k);
      end else begin
        want = exp_q.pop_front();
      end
      wait_pulses(8);
      @(negedge clk);
      total++;
      if (tx !== want) begin
        bad++;
        $display("[TB] FAIL %s_bit%0d: got tx=%b want %b", tag, k, tx, want);
      end
      total++;
      if (sreg_empty !== 1'b0) begin
        bad++;
        $display("[TB] FAIL %s_busy%0d: got sreg_empty=%b want 0", tag, k, sreg_empty);
      end
      if (k == brk_at) begin
        set_break = 1'b1;
        #1;
        total++;
        if (tx !== 1'b0) begin
          bad++;
          $display("[TB] FAIL %s_break_on: got tx=%b want 0", tag, tx);
        end
        wait_pulses(4);
        @(negedge clk);
        total++;
        if (tx !== 1'b0) begin
          bad++;
          $display("[TB] FAIL %s_break_hold: got tx=%b want 0", tag, tx);
        end
        set_break = 1'b0;
        #1;
        total++;
        if (tx !== want) begin
          bad++;
          $display("[TB] FAIL %s_break_off: got tx=%b want %b", tag, tx, want);
        end
        wait_pulses(4);
      end else begin
        wait_pulses(8);
      end
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    total++;
    if (sreg_empty !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s_empty: got sreg_empty=%b want 1", tag, sreg_empty);
    end
    total++;
    if (tx !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s_idle_tx: got tx=%b want 1", tag, tx);
    end
  endtask

  // Single character; frame inputs are scrambled after the load to show they were latched.
  task automatic run_frame(input logic [7:0] d, input logic [1:0] w, input logic p,
                           input logic e, input logic s, input logic sb,
                           input int brk_at, input string tag);
    set_cfg(w, p, e, s, sb);
    fifo.din = d;
    push_frame(d, w, p, e, s, sb);
    fifo.thre = 1'b0;
    wait_pop(tag);
    fifo.thre = 1'b1;
    wls = ~w; pen = ~p; eps = ~e; sticky_parity = ~s; stb = ~sb;
    fifo.din = ~d;
    @(negedge clk);
    total++;
    if (fifo.pop !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s_pop_width: got pop=%b want 0 one clock later", tag, fifo.pop);
    end
    check_bits(1 + int'(w) + 5 + int'(p) + 1 + int'(sb), brk_at, tag);
    check_idle(tag);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (tx !== 1'b1) begin bad++; $display("[TB] FAIL reset_tx: got %b want 1", tx); end
    total++;
    if (fifo.pop !== 1'b0) begin bad++; $display("[TB] FAIL reset_pop: got %b want 0", fifo.pop); end
    total++;
    if (sreg_empty !== 1'b1) begin bad++; $display("[TB] FAIL reset_empty: got %b want 1", sreg_empty); end
    rst = 1'b1;
    wait_pulses(3);
    @(negedge clk);
    total++;
    if (tx !== 1'b1 || fifo.pop !== 1'b0) begin
      bad++;
      $display("[TB] FAIL idle_hold: got tx=%b pop=%b want 1 0", tx, fifo.pop);
    end
  endtask

  task automatic test_parity();
    run_frame(8'h13, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, -1, "par_even");
    run_frame(8'h13, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, -1, "par_odd");
    run_frame(8'h13, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, -1, "stick_e1");
    run_frame(8'h13, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, -1, "stick_e0");
    run_frame(8'h6C, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, -1, "par_7bit");
  endtask

  task automatic test_short_word();
    run_frame(8'hFF, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, -1, "short5");
  endtask

  task automatic test_back_to_back();
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    fifo.din = 8'hA5;
    push_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    fifo.thre = 1'b0;
    wait_pop("b2b_first");
    fifo.din = 8'h3C;
    push_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    check_bits(10, -1, "b2b_a");
    @(negedge clk);
    total++;
    if (fifo.pop !== 1'b1) begin
      bad++;
      $display("[TB] FAIL b2b_second_pop: got pop=%b want 1 at last stop tick", fifo.pop);
    end
    total++;
    if (sreg_empty !== 1'b0 || tx !== 1'b0) begin
      bad++;
      $display("[TB] FAIL b2b_no_gap: got empty=%b tx=%b want 0 0", sreg_empty, tx);
    end
    fifo.thre = 1'b1;
    check_bits(10, -1, "b2b_b");
    check_idle("b2b");
  endtask

  task automatic test_break();
    run_frame(8'h13, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2, "break");
  endtask

  task automatic test_stop_len();
    int cnt;
    int g;
    int want;
`ifdef UART_TX_HALF_STOP_EN
    want = 120;
`else
    want = 128;
`endif
    set_cfg(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    fifo.din = 8'h0A;
    fifo.thre = 1'b0;
    wait_pop("stoplen");
    cnt = 0;
    g   = 0;
    do begin
      @(posedge clk);
      if (baud_pulse) cnt++;
      @(negedge clk);
      g++;
    end while (fifo.pop !== 1'b1 && g < 2000);
    fifo.thre = 1'b1;
    total++;
    if (fifo.pop !== 1'b1 || cnt != want) begin
      bad++;
      $display("[TB] FAIL stop_len: got %0d ticks between pops want %0d", cnt, want);
    end
    g = 0;
    while (sreg_empty !== 1'b1 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    total++;
    if (sreg_empty !== 1'b1) begin
      bad++;
      $display("[TB] FAIL stop_len_idle: got sreg_empty=%b want 1", sreg_empty);
    end
  endtask

  task automatic test_reset_midframe();
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    fifo.din = 8'h00;
    fifo.thre = 1'b0;
    wait_pop("midrst");
    fifo.thre = 1'b1;
    wait_pulses(4);
    @(negedge clk);
    #2;
    total++;
    if (tx !== 1'b0) begin bad++; $display("[TB] FAIL midrst_start: got tx=%b want 0", tx); end
    rst = 1'b0;
    #1;
    total++;
    if (tx !== 1'b1 || sreg_empty !== 1'b1 || fifo.pop !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midrst_async: got tx=%b empty=%b pop=%b want 1 1 0", tx, sreg_empty, fifo.pop);
    end
    #3;
    rst = 1'b1;
    wait_pulses(20);
    check_idle("midrst");
  endtask

  initial begin
    rst = 1'b0;
    fifo.din = 8'h00;
    fifo.thre = 1'b1;
    set_break = 1'b0;
    set_cfg(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_parity();
    test_short_word();
    test_back_to_back();
    test_break();
    test_stop_len();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Transmit half of a 16550-style UART.
- Takes one character from the transmit holding register/FIFO (din), serialises it LSB-first on tx with programmable word length, parity and stop bits, and forces a break condition on request.
- Bit timing is derived from an external baud_pulse tick at 16x the bit rate.
- Sits between the TX FIFO/THR and the serial output pin; line-control bits come from the LCR.

Parameters:
- OVERSAMPLE, 16, baud_pulse ticks per serial bit; must be even and at least 2.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous active-low reset (rst=0 resets).
- baud_pulse  in  1  one-clk-wide tick at OVERSAMPLE x bit rate; FSM advances only on clocks where baud_pulse=1.
- pen  in  1  parity enable.
- thre  in  1  holding register empty; 0 means a character is available on din.
- stb  in  1  stop-bit select: 0 = 1 stop bit; 1 = 2 stop bits (1.5 for 5-bit words, see Optional Feature).
- sticky_parity  in  1  stick parity enable.
- eps  in  1  even parity select (1 = even, 0 = odd).
- set_break  in  1  force tx low.
- din  in  8  character to send; only bits [wls+4:0] are transmitted.
- wls  in  2  word length: 00=5, 01=6, 10=7, 11=8 bits.
- pop  out  1  one-clk pulse: character on din consumed; advance the FIFO.
- sreg_empty  out  1  1 when the shift register is idle (no frame in progress).
- tx  out  1  serial output; idle high.

Behaviour:
- Reset (rst=0, async): state=IDLE, tx register=1, pop=0, sreg_empty=1, tick counter=0, bit counter=0.
- States: IDLE, START, DATA, PARITY, STOP. The tick counter counts baud_pulses within a bit; a bit ends when the counter reaches OVERSAMPLE-1.
- IDLE:
  - tx=1, sreg_empty=1.
  - On a clock with baud_pulse=1 and thre=0: latch din into the shift register, latch wls/pen/eps/sticky_parity/stb for the frame, pulse pop=1 for exactly that clock, set sreg_empty=0, go to START.
  - If thre=1, stay in IDLE.
- START: tx=0 for OVERSAMPLE ticks, then go to DATA.
- DATA:
  - tx = shift register bit 0; shift right after each bit.
  - Send exactly wls+5 bits, then go to PARITY if pen=1, else STOP.
- PARITY:
  - sticky_parity=0: bit = XOR of transmitted data bits, inverted when eps=0. Even parity gives an even total count of ones including the parity bit.
  - sticky_parity=1: bit = ~eps (eps=1 sends 0, eps=0 sends 1).
  - Lasts one bit time, then go to STOP.
- STOP:
  - tx=1 for OVERSAMPLE ticks if stb=0, or 2*OVERSAMPLE ticks if stb=1.
  - Then, on the final tick, if thre=0: load the next character immediately (pop pulse, go to START, sreg_empty stays 0). Otherwise go to IDLE and set sreg_empty=1.
- Frame settings are sampled at load time; changes mid-frame affect only the next frame.
- set_break: the tx pin is combinationally the internal tx register AND NOT set_break. The FSM keeps running underneath; releasing break mid-frame resumes the in-progress bit.
- Clocks without baud_pulse hold all state. pop is never asserted outside a load clock.

Optional Feature:
- Macro UART_TX_HALF_STOP_EN.
- Defined: when stb=1 and the latched wls=00, the stop period is 1.5 bits (OVERSAMPLE*3/2 ticks).
- Not defined: stb=1 always gives 2 stop bits regardless of word length.

Test Plan:
- Reset: hold rst=0 for 5 clocks -> tx=1, pop=0, sreg_empty=1. Assert rst=0 mid-frame -> tx=1 and IDLE immediately, without waiting for a clock edge.
- baud_pulse every 6th clk, thre=0, din=0x13, wls=11, pen=1, eps=1, stb=1, sticky_parity=0 -> single-clk pop. tx sequence, each bit 96 clks: 0 | 1,1,0,0,1,0,0,0 | parity 1 | 1,1.
- Same with eps=0 -> parity bit 0. With sticky_parity=1, eps=1 -> parity 0; eps=0 -> parity 1.
- wls=00, din=0xFF, pen=0, stb=0 -> start, five 1s, one stop bit; total 7 bit times. din bits [7:5] are never sent.
- thre held 0 for two characters -> second pop occurs on the last stop tick, and the next start bit follows without any idle bit. sreg_empty stays 0 throughout; it rises only after thre=1 and the final stop bit.
- set_break=1 mid-DATA -> tx=0 immediately. Deassert -> tx returns to the current FSM bit value; frame timing is unchanged.
